can_tx_mailbox_arbiter: RTL and testbench

Schedules transmission of CAN frames from NUM_MB transmit mailboxes onto the single TX engine handshake. Each mailbox holds one 128-bit frame in controller register format, with the ID word in bits [127:96]. The block always offers the pending frame with the numerically lowest ID word to the engine, and re-arbitrates after every completion or arbitration loss. It sits between the host register/FIFO side and the TX bit engine, in the i_sys_clk domain; any CDC to the engine is handled outside this block.

---
 rtl/can_tx_pkg.sv | 25 ++
 rtl/can_tx_prio_select.sv | 40 ++++
 rtl/can_tx_mailbox_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_can_tx_mailbox_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_tx_pkg.sv
// ---------------------------------------------------------------------------
// can_tx_pkg
// Shared types and constants for the CAN transmit mailbox arbiter:
//   state_t  - arbiter FSM states (IDLE, SELECT, REQ, WAIT)
//   frame_t  - 128-bit frame in controller register format
//   ID_MSB/ID_LSB/ID_W - location of the ID word used for arbitration
//   RETRY_W  - width of the per-mailbox arbitration-loss retry counter
// ---------------------------------------------------------------------------
package can_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        REQ    = 2'd2,
        WAIT   = 2'd3
    } state_t;

    typedef logic [127:0] frame_t;

    localparam int ID_MSB  = 127;
    localparam int ID_LSB  = 96;
    localparam int ID_W    = ID_MSB - ID_LSB + 1;
    localparam int RETRY_W = 4;

endpackage

// File: rtl/can_tx_prio_select.sv
// ---------------------------------------------------------------------------
// can_tx_prio_select
// Combinational lowest-ID finder across the valid mailboxes.
// Ports:
//   valid    in  NUM_MB        mailbox valid bits
//   id_words in  ID_W x NUM_MB ID word of each mailbox
//   win_idx  out clog2(NUM_MB) index of the lowest ID (lowest index on ties)
//   found    out 1             at least one mailbox is valid
// ---------------------------------------------------------------------------
module can_tx_prio_select
    import can_tx_pkg::*;
#(
    parameter int NUM_MB = 4
) (
    input  logic [NUM_MB-1:0]         valid,
    input  logic [ID_W-1:0]           id_words [NUM_MB],
    output logic [$clog2(NUM_MB)-1:0] win_idx,
    output logic                      found
);

    localparam int IDX_W = $clog2(NUM_MB);

    logic [ID_W-1:0] best_id;

    // Ascending scan with a strict less-than: an equal ID found later never
    // displaces an earlier one, which gives the lowest-index tie break.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        best_id = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (valid[i] && (!found || (id_words[i] < best_id))) begin
                found   = 1'b1;
                win_idx = IDX_W'(i);
                best_id = id_words[i];
            end
        end
    end

endmodule

// File: rtl/can_tx_mailbox_arbiter.sv
// ---------------------------------------------------------------------------
// can_tx_mailbox_arbiter
// Holds NUM_MB transmit mailboxes and always offers the pending frame with
// the lowest ID word to the TX engine, re-arbitrating after each completion
// or arbitration loss.
// Ports:
//   i_sys_clk, i_reset (sync, active high)
//   i_cen                          controller enable
//   i_mb_wr_en/_sel/_data          mailbox write port
//   i_abort[NUM_MB]                per-mailbox abort pulses
//   i_tx_busy, i_tx_done, i_arb_lost  engine handshake/status
//   o_send_data, o_send_en         frame offer to the engine
//   o_mb_pending                   registered mailbox valid bits
//   o_done, o_done_idx             completion pulse and mailbox index
//   o_wr_err                       write rejected (target in flight)
//   o_fail                         mailbox dropped after MAX_RETRY losses
// Build option: define CAN_TX_RETRY_LIMIT_EN to build per-mailbox retry
// counters and the drop-on-limit behaviour; otherwise losses retry forever
// and o_fail is tied low.
// ---------------------------------------------------------------------------
module can_tx_mailbox_arbiter
    import can_tx_pkg::*;
#(
    parameter int NUM_MB    = 4,
    parameter int MAX_RETRY = 15
) (
    input  logic                      i_sys_clk,
    input  logic                      i_reset,
    input  logic                      i_cen,
    input  logic                      i_mb_wr_en,
    input  logic [$clog2(NUM_MB)-1:0] i_mb_wr_sel,
    input  logic [127:0]              i_mb_wr_data,
    input  logic [NUM_MB-1:0]         i_abort,
    input  logic                      i_tx_busy,
    input  logic                      i_tx_done,
    input  logic                      i_arb_lost,
    output logic [127:0]              o_send_data,
    output logic                      o_send_en,
    output logic [NUM_MB-1:0]         o_mb_pending,
    output logic                      o_done,
    output logic [$clog2(NUM_MB)-1:0] o_done_idx,
    output logic                      o_wr_err,
    output logic                      o_fail
);

    localparam int IDX_W = $clog2(NUM_MB);

    state_t            state_reg;
    logic [IDX_W-1:0]  sel_idx_reg;
    logic [IDX_W-1:0]  done_idx_reg;
    logic [NUM_MB-1:0] valid_reg;
    logic [NUM_MB-1:0] abort_flag_reg;
    frame_t            send_data_reg;
    logic              send_en_reg;
    logic              done_reg;
    logic              wr_err_reg;
    frame_t            mb_data_reg [NUM_MB];

    logic [ID_W-1:0]   id_words [NUM_MB];
    logic [NUM_MB-1:0] wr_hit;
    logic [NUM_MB-1:0] in_flight;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic              abort_sel;

`ifdef CAN_TX_RETRY_LIMIT_EN
    logic [RETRY_W-1:0] retry_cnt_reg [NUM_MB];
    logic               fail_reg;
`else
    logic [RETRY_W-1:0] unused_max_retry;
    assign unused_max_retry = RETRY_W'(MAX_RETRY);
`endif

    // While in SELECT, sel_idx_reg still holds the previous winner, so the
    // mailbox being picked this cycle (win_idx) is the one treated as in
    // flight. That keeps a same-cycle write from racing the data latch.
    for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_mb
        assign id_words[gi]  = mb_data_reg[gi][ID_MSB:ID_LSB];
        assign wr_hit[gi]    = i_mb_wr_en && (i_mb_wr_sel == IDX_W'(gi));
        assign in_flight[gi] = (state_reg == SELECT)
                             ? (win_found && (win_idx == IDX_W'(gi)))
                             : ((state_reg != IDLE) && (sel_idx_reg == IDX_W'(gi)));
    end

    // An abort arriving in the same cycle as the decision still counts.
    assign abort_sel = abort_flag_reg[sel_idx_reg] | i_abort[sel_idx_reg];

    can_tx_prio_select #(
        .NUM_MB   (NUM_MB)
    ) u_prio_select (
        .valid    (valid_reg),
        .id_words (id_words),
        .win_idx  (win_idx),
        .found    (win_found)
    );

    // Frame storage: written only when the target is not in flight.
    always_ff @(posedge i_sys_clk) begin
        for (int i = 0; i < NUM_MB; i++) begin
            if (wr_hit[i] && !in_flight[i]) begin
                mb_data_reg[i] <= i_mb_wr_data;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            sel_idx_reg    <= '0;
            done_idx_reg   <= '0;
            valid_reg      <= '0;
            abort_flag_reg <= '0;
            send_data_reg  <= '0;
            send_en_reg    <= 1'b0;
            done_reg       <= 1'b0;
            wr_err_reg     <= 1'b0;
`ifdef CAN_TX_RETRY_LIMIT_EN
            fail_reg       <= 1'b0;
            for (int i = 0; i < NUM_MB; i++) retry_cnt_reg[i] <= '0;
`endif
        end else begin
            done_reg   <= 1'b0;
            wr_err_reg <= |(wr_hit & in_flight);
`ifdef CAN_TX_RETRY_LIMIT_EN
            fail_reg   <= 1'b0;
`endif
            // Mailbox side: a write beats an abort on the same mailbox.
            for (int i = 0; i < NUM_MB; i++) begin
                if (wr_hit[i] && !in_flight[i]) begin
                    valid_reg[i] <= 1'b1;
`ifdef CAN_TX_RETRY_LIMIT_EN
                    // A fresh frame starts with a fresh retry budget.
                    retry_cnt_reg[i] <= '0;
`endif
                end else if (i_abort[i]) begin
                    if (in_flight[i]) abort_flag_reg[i] <= 1'b1;
                    else              valid_reg[i]      <= 1'b0;
                end
            end

            // FSM assignments come last so they override the loop above.
            case (state_reg)
                IDLE: begin
                    if (i_cen && (|valid_reg)) state_reg <= SELECT;
                end
                SELECT: begin
                    if (!win_found) begin
                        state_reg <= IDLE;
                    end else if (!i_cen && !i_tx_busy) begin
                        // Not offered yet, so an abort just taken is honoured now.
                        state_reg               <= IDLE;
                        abort_flag_reg[win_idx] <= 1'b0;
                        if (i_abort[win_idx]) valid_reg[win_idx] <= 1'b0;
                    end else begin
                        sel_idx_reg   <= win_idx;
                        send_data_reg <= mb_data_reg[win_idx];
                        send_en_reg   <= 1'b1;
                        state_reg     <= REQ;
                    end
                end
                REQ: begin
                    if (i_tx_busy) begin
                        send_en_reg <= 1'b0;
                        state_reg   <= WAIT;
                    end else if (!i_cen) begin
                        send_en_reg                 <= 1'b0;
                        state_reg                   <= IDLE;
                        abort_flag_reg[sel_idx_reg] <= 1'b0;
                        if (abort_sel) valid_reg[sel_idx_reg] <= 1'b0;
                    end
                end
                WAIT: begin
                    if (i_tx_done) begin
                        valid_reg[sel_idx_reg]      <= 1'b0;
                        abort_flag_reg[sel_idx_reg] <= 1'b0;
                        done_reg                    <= 1'b1;
                        done_idx_reg                <= sel_idx_reg;
                        state_reg                   <= IDLE;
`ifdef CAN_TX_RETRY_LIMIT_EN
                        retry_cnt_reg[sel_idx_reg]  <= '0;
`endif
                    end else if (i_arb_lost) begin
                        abort_flag_reg[sel_idx_reg] <= 1'b0;
                        state_reg                   <= IDLE;
                        if (abort_sel) begin
                            valid_reg[sel_idx_reg] <= 1'b0;
                        end
`ifdef CAN_TX_RETRY_LIMIT_EN
                        else if (retry_cnt_reg[sel_idx_reg] == RETRY_W'(MAX_RETRY)) begin
                            valid_reg[sel_idx_reg]     <= 1'b0;
                            retry_cnt_reg[sel_idx_reg] <= '0;
                            fail_reg                   <= 1'b1;
                            done_idx_reg               <= sel_idx_reg;
                        end else if (retry_cnt_reg[sel_idx_reg] != '1) begin
                            retry_cnt_reg[sel_idx_reg] <= retry_cnt_reg[sel_idx_reg] + 1'b1;
                        end
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_send_data  = send_data_reg;
    assign o_send_en    = send_en_reg;
    assign o_mb_pending = valid_reg;
    assign o_done       = done_reg;
    assign o_done_idx   = done_idx_reg;
    assign o_wr_err     = wr_err_reg;
`ifdef CAN_TX_RETRY_LIMIT_EN
    assign o_fail       = fail_reg;
`else
    assign o_fail       = 1'b0;
`endif

endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// ---------------------------------------------------------------------------
// tb_can_tx_mailbox_arbiter
// Self-checking bench for can_tx_mailbox_arbiter (NUM_MB=4, MAX_RETRY=2).
// Expected completion indices are queued when a completion is stimulated and
// compared by a monitor when o_done pulses; other checks are inline.
// ---------------------------------------------------------------------------
module tb_can_tx_mailbox_arbiter;
    import can_tx_pkg::*;

    localparam int NUM_MB = 4;

    logic         clk;
    logic         i_reset;
    logic         i_cen;
    logic         i_mb_wr_en;
    logic [1:0]   i_mb_wr_sel;
    logic [127:0] i_mb_wr_data;
    logic [3:0]   i_abort;
    logic         i_tx_busy;
    logic         i_tx_done;
    logic         i_arb_lost;
    logic [127:0] o_send_data;
    logic         o_send_en;
    logic [3:0]   o_mb_pending;
    logic         o_done;
    logic [1:0]   o_done_idx;
    logic         o_wr_err;
    logic         o_fail;

    int test_cnt = 0;
    int fail_cnt = 0;
    int exp_done_q [$];

    can_tx_mailbox_arbiter #(
        .NUM_MB       (NUM_MB),
        .MAX_RETRY    (2)
    ) dut (
        .i_sys_clk    (clk),
        .i_reset      (i_reset),
        .i_cen        (i_cen),
        .i_mb_wr_en   (i_mb_wr_en),
        .i_mb_wr_sel  (i_mb_wr_sel),
        .i_mb_wr_data (i_mb_wr_data),
        .i_abort      (i_abort),
        .i_tx_busy    (i_tx_busy),
        .i_tx_done    (i_tx_done),
        .i_arb_lost   (i_arb_lost),
        .o_send_data  (o_send_data),
        .o_send_en    (o_send_en),
        .o_mb_pending (o_mb_pending),
        .o_done       (o_done),
        .o_done_idx   (o_done_idx),
        .o_wr_err     (o_wr_err),
        .o_fail       (o_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completion monitor: every o_done must match the oldest queued index.
    always @(negedge clk) begin : mon
        int e;
        if (o_done === 1'b1) begin
            test_cnt++;
            if (exp_done_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL done_unexpected: got o_done=1 idx=%0d, required no completion", o_done_idx);
            end else begin
                e = exp_done_q.pop_front();
                if (o_done_idx !== 2'(e)) begin
                    fail_cnt++;
                    $display("FAIL done_idx: got %0d required %0d", o_done_idx, e);
                end else begin
                    $display("[TB] done idx=%0d", o_done_idx);
                end
            end
        end
    end

    function automatic frame_t mk(input logic [31:0] id, input logic [7:0] tag);
        return {id, 56'h0, 32'h1234_5678, tag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic write_mb(input int idx, input frame_t f);
        i_mb_wr_en   = 1'b1;
        i_mb_wr_sel  = 2'(idx);
        i_mb_wr_data = f;
        tick();
        i_mb_wr_en   = 1'b0;
    endtask

    task automatic wait_offer(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (o_send_en === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        test_cnt++;
        fail_cnt++;
        $display("FAIL offer_timeout: got o_send_en=0 for 40 cycles, required 1");
    endtask

    // Accept the offer, check its frame, then complete it successfully.
    task automatic serve(input frame_t exp, input int idx, input string nm);
        bit ok;
        wait_offer(ok);
        if (!ok) return;
        test_cnt++;
        if (o_send_data !== exp) begin
            fail_cnt++;
            $display("FAIL %s_data: got %h required %h", nm, o_send_data, exp);
        end else begin
            $display("[TB] %s offered %h", nm, o_send_data);
        end
        i_tx_busy = 1'b1;
        tick();
        test_cnt++;
        if (o_send_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL %s_send_en_drop: got %b required 0", nm, o_send_en);
        end
        tick();
        exp_done_q.push_back(idx);
        i_tx_done = 1'b1;
        i_tx_busy = 1'b0;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        test_cnt++;
        if ({o_send_en, o_done, o_wr_err, o_fail} !== 4'b0) begin
            fail_cnt++;
            $display("FAIL reset_flags: got %b required 0000", {o_send_en, o_done, o_wr_err, o_fail});
        end
        test_cnt++;
        if (o_mb_pending !== 4'b0) begin
            fail_cnt++;
            $display("FAIL reset_pending: got %b required 0000", o_mb_pending);
        end
        test_cnt++;
        if (o_send_data !== 128'h0 || o_done_idx !== 2'd0) begin
            fail_cnt++;
            $display("FAIL reset_data: got %h/%0d required 0/0", o_send_data, o_done_idx);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_timing();
        i_cen = 1'b1;
        tick();
        i_mb_wr_en   = 1'b1;
        i_mb_wr_sel  = 2'd1;
        i_mb_wr_data = mk(32'h0000_0300, 8'h11);
        tick();
        i_mb_wr_en = 1'b0;
        test_cnt++;
        if (o_mb_pending !== 4'b0010 || o_send_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL timing_e1: got pend=%b en=%b required 0010/0", o_mb_pending, o_send_en);
        end
        tick();
        test_cnt++;
        if (o_send_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL timing_e2: got en=%b required 0", o_send_en);
        end
        tick();
        test_cnt++;
        if (o_send_en !== 1'b1) begin
            fail_cnt++;
            $display("FAIL timing_e3: got en=%b required 1", o_send_en);
        end
        serve(mk(32'h0000_0300, 8'h11), 1, "timing");
    endtask

    task automatic test_priority();
        i_cen = 1'b0;
        write_mb(0, mk(32'h2000_0000, 8'hA0));
        write_mb(2, mk(32'h1000_0000, 8'hA2));
        test_cnt++;
        if (o_mb_pending !== 4'b0101) begin
            fail_cnt++;
            $display("FAIL prio_pending: got %b required 0101", o_mb_pending);
        end
        i_cen = 1'b1;
        serve(mk(32'h1000_0000, 8'hA2), 2, "prio_mb2");
        // Re-arbitration: IDLE, then SELECT, then the next offer.
        test_cnt++;
        if (o_send_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL rearb_c1: got en=%b required 0", o_send_en);
        end
        tick();
        test_cnt++;
        if (o_send_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL rearb_c2: got en=%b required 0", o_send_en);
        end
        tick();
        test_cnt++;
        if (o_send_en !== 1'b1) begin
            fail_cnt++;
            $display("FAIL rearb_c3: got en=%b required 1", o_send_en);
        end
        serve(mk(32'h2000_0000, 8'hA0), 0, "prio_mb0");
        test_cnt++;
        if (o_mb_pending !== 4'b0000) begin
            fail_cnt++;
            $display("FAIL prio_empty: got %b required 0000", o_mb_pending);
        end
    endtask

    task automatic test_tie();
        i_cen = 1'b0;
        write_mb(3, mk(32'h0AA0_0000, 8'hB3));
        write_mb(1, mk(32'h0AA0_0000, 8'hB1));
        i_cen = 1'b1;
        serve(mk(32'h0AA0_0000, 8'hB1), 1, "tie_mb1");
        serve(mk(32'h0AA0_0000, 8'hB3), 3, "tie_mb3");
    endtask

    task automatic test_wr_err();
        bit ok;
        i_cen = 1'b0;
        write_mb(0, mk(32'h0000_0100, 8'hC0));
        i_cen = 1'b1;
        wait_offer(ok);
        write_mb(0, mk(32'h0000_0050, 8'hEE));
        test_cnt++;
        if (o_wr_err !== 1'b1) begin
            fail_cnt++;
            $display("FAIL wr_err_pulse: got %b required 1", o_wr_err);
        end
        tick();
        test_cnt++;
        if (o_wr_err !== 1'b0 || o_send_data !== mk(32'h0000_0100, 8'hC0)) begin
            fail_cnt++;
            $display("FAIL wr_err_hold: got err=%b data=%h required 0/%h", o_wr_err, o_send_data, mk(32'h0000_0100, 8'hC0));
        end
        write_mb(1, mk(32'h0000_0200, 8'hC1));
        test_cnt++;
        if (o_mb_pending !== 4'b0011 || o_wr_err !== 1'b0) begin
            fail_cnt++;
            $display("FAIL wr_other: got pend=%b err=%b required 0011/0", o_mb_pending, o_wr_err);
        end
        serve(mk(32'h0000_0100, 8'hC0), 0, "wr_mb0");
        serve(mk(32'h0000_0200, 8'hC1), 1, "wr_mb1");
    endtask

    task automatic test_arb_lost();
        bit ok;
        i_cen = 1'b0;
        write_mb(0, mk(32'h0000_0500, 8'hD0));
        i_cen = 1'b1;
        wait_offer(ok);
        i_tx_busy = 1'b1;
        tick();
        write_mb(1, mk(32'h0000_0100, 8'hD1));
        i_arb_lost = 1'b1;
        i_tx_busy  = 1'b0;
        tick();
        i_arb_lost = 1'b0;
        test_cnt++;
        if (o_mb_pending !== 4'b0011) begin
            fail_cnt++;
            $display("FAIL arb_pending: got %b required 0011", o_mb_pending);
        end
        serve(mk(32'h0000_0100, 8'hD1), 1, "arb_mb1");
        serve(mk(32'h0000_0500, 8'hD0), 0, "arb_mb0");
    endtask

    task automatic test_abort();
        bit ok;
        i_cen = 1'b1;
        // Abort in WAIT, then arbitration loss: dropped silently.
        write_mb(0, mk(32'h0000_0700, 8'hE0));
        wait_offer(ok);
        i_tx_busy = 1'b1;
        tick();
        i_abort = 4'b0001;
        tick();
        i_abort    = 4'b0000;
        i_arb_lost = 1'b1;
        i_tx_busy  = 1'b0;
        tick();
        i_arb_lost = 1'b0;
        test_cnt++;
        if (o_mb_pending !== 4'b0000) begin
            fail_cnt++;
            $display("FAIL abort_lost_pending: got %b required 0000", o_mb_pending);
        end
        repeat (5) tick();
        test_cnt++;
        if (o_send_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL abort_lost_idle: got en=%b required 0", o_send_en);
        end
        // Abort in WAIT, then success: completion still reported.
        write_mb(0, mk(32'h0000_0700, 8'hE1));
        wait_offer(ok);
        i_tx_busy = 1'b1;
        tick();
        i_abort = 4'b0001;
        tick();
        i_abort = 4'b0000;
        exp_done_q.push_back(0);
        i_tx_done = 1'b1;
        i_tx_busy = 1'b0;
        tick();
        i_tx_done = 1'b0;
        test_cnt++;
        if (o_mb_pending !== 4'b0000) begin
            fail_cnt++;
            $display("FAIL abort_done_pending: got %b required 0000", o_mb_pending);
        end
        // Abort of a pending, idle mailbox; then write+abort same cycle.
        i_cen = 1'b0;
        write_mb(2, mk(32'h0000_0900, 8'hE2));
        i_abort = 4'b0100;
        tick();
        i_abort = 4'b0000;
        test_cnt++;
        if (o_mb_pending !== 4'b0000) begin
            fail_cnt++;
            $display("FAIL abort_idle: got %b required 0000", o_mb_pending);
        end
        i_abort = 4'b0100;
        write_mb(2, mk(32'h0000_0900, 8'hE3));
        i_abort = 4'b0000;
        test_cnt++;
        if (o_mb_pending !== 4'b0100) begin
            fail_cnt++;
            $display("FAIL abort_vs_write: got %b required 0100", o_mb_pending);
        end
        i_abort = 4'b0100;
        tick();
        i_abort = 4'b0000;
        i_cen   = 1'b1;
    endtask

    task automatic test_cen_drop();
        bit ok;
        i_cen = 1'b1;
        write_mb(3, mk(32'h0000_0A00, 8'hF3));
        wait_offer(ok);
        i_cen = 1'b0;
        tick();
        test_cnt++;
        if (o_send_en !== 1'b0 || o_mb_pending !== 4'b1000) begin
            fail_cnt++;
            $display("FAIL cen_drop: got en=%b pend=%b required 0/1000", o_send_en, o_mb_pending);
        end
        repeat (3) tick();
        test_cnt++;
        if (o_send_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL cen_hold: got en=%b required 0", o_send_en);
        end
        i_cen = 1'b1;
        serve(mk(32'h0000_0A00, 8'hF3), 3, "cen_mb3");
    endtask

    task automatic test_retry();
        bit ok;
        i_cen = 1'b1;
        write_mb(2, mk(32'h0000_0B00, 8'h72));
        for (int k = 1; k <= 3; k++) begin
            wait_offer(ok);
            i_tx_busy = 1'b1;
            tick();
            i_arb_lost = 1'b1;
            i_tx_busy  = 1'b0;
            tick();
            i_arb_lost = 1'b0;
`ifdef CAN_TX_RETRY_LIMIT_EN
            test_cnt++;
            if (k < 3) begin
                if (o_fail !== 1'b0 || o_mb_pending !== 4'b0100) begin
                    fail_cnt++;
                    $display("FAIL retry_%0d: got fail=%b pend=%b required 0/0100", k, o_fail, o_mb_pending);
                end
            end else begin
                if (o_fail !== 1'b1 || o_mb_pending !== 4'b0000 || o_done_idx !== 2'd2) begin
                    fail_cnt++;
                    $display("FAIL retry_drop: got fail=%b pend=%b idx=%0d required 1/0000/2", o_fail, o_mb_pending, o_done_idx);
                end
            end
`else
            test_cnt++;
            if (o_fail !== 1'b0 || o_mb_pending !== 4'b0100) begin
                fail_cnt++;
                $display("FAIL retry_inf_%0d: got fail=%b pend=%b required 0/0100", k, o_fail, o_mb_pending);
            end
`endif
            $display("[TB] retry loss %0d", k);
        end
`ifdef CAN_TX_RETRY_LIMIT_EN
        tick();
        test_cnt++;
        if (o_fail !== 1'b0 || o_send_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL retry_after: got fail=%b en=%b required 0/0", o_fail, o_send_en);
        end
`else
        serve(mk(32'h0000_0B00, 8'h72), 2, "retry_mb2");
`endif
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        i_cen = 1'b1;
        write_mb(0, mk(32'h0000_0C00, 8'h80));
        write_mb(1, mk(32'h0000_0D00, 8'h81));
        wait_offer(ok);
        i_tx_busy = 1'b1;
        tick();
        i_reset = 1'b1;
        tick();
        test_cnt++;
        if ({o_send_en, o_done, o_wr_err, o_fail} !== 4'b0 || o_mb_pending !== 4'b0
            || o_send_data !== 128'h0 || o_done_idx !== 2'd0) begin
            fail_cnt++;
            $display("FAIL reset_in_wait: got en=%b pend=%b data=%h required all 0", o_send_en, o_mb_pending, o_send_data);
        end
        i_reset   = 1'b0;
        i_tx_busy = 1'b0;
        repeat (4) tick();
        test_cnt++;
        if (o_send_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_in_wait_idle: got en=%b required 0", o_send_en);
        end
        $display("[TB] reset during WAIT checked");
    endtask

    initial begin
        i_reset      = 1'b1;
        i_cen        = 1'b0;
        i_mb_wr_en   = 1'b0;
        i_mb_wr_sel  = 2'd0;
        i_mb_wr_data = '0;
        i_abort      = 4'b0;
        i_tx_busy    = 1'b0;
        i_tx_done    = 1'b0;
        i_arb_lost   = 1'b0;

        test_reset();
        test_timing();
        test_priority();
        test_tie();
        test_wr_err();
        test_arb_lost();
        test_abort();
        test_cen_drop();
        test_retry();
        test_reset_in_wait();

        test_cnt++;
        if (exp_done_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL done_missing: got %0d outstanding completions, required 0", exp_done_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
